// File: rtl/lc3_ctrl_fsm_p.sv
// LC-3 microsequencer with READY-gated memory states, bounded wait timeout, interrupt entry and RTI.
// State, wait counter and the sticky error flag are the only flops; every strobe decodes from the current state.
module lc3_ctrl_fsm_p #(
    parameter int DATA_W       = 16,
    parameter int MEM_WAIT_MAX = 15,
    parameter int INT_EN       = 1,
    parameter int CNT_W        = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              READY,
    input  logic [DATA_W-1:0] IR,
    input  logic              N,
    input  logic              Z,
    input  logic              P,
    input  logic              INT_REQ,
    output logic              LD_MAR,
    output logic              LD_MDR,
    output logic              LD_IR,
    output logic              LD_PC,
    output logic              LD_REG,
    output logic              LD_BEN,
    output logic              LD_CC,
    output logic              GateMARMUX,
    output logic              GateMDR,
    output logic              GateALU,
    output logic              GatePC,
    output logic              MARMUXsel,
    output logic              ADDR1MUXsel,
    output logic [1:0]        ADDR2MUXsel,
    output logic [1:0]        PCMUXsel,
    output logic [1:0]        SR1MUXsel,
    output logic [1:0]        DRMUXsel,
    output logic [1:0]        ALUK,
    output logic              MEM_EN,
    output logic              MEM_WE,
    output logic              INT_ACK,
    output logic              MEM_ERR,
    output logic              HALTED
);

    typedef enum logic [5:0] {
        S_BR1    = 6'd0,  S_ADD    = 6'd1,  S_LD     = 6'd2,  S_ST     = 6'd3,
        S_JSR    = 6'd4,  S_AND    = 6'd5,  S_LDR    = 6'd6,  S_STR    = 6'd7,
        S_RTI    = 6'd8,  S_NOT    = 6'd9,  S_LDI1   = 6'd10, S_STI1   = 6'd11,
        S_JMP    = 6'd12, S_LEA    = 6'd14, S_TRAP1  = 6'd15, S_MEM22  = 6'd16,
        S_FETCH1 = 6'd18, S_JSR0   = 6'd20, S_JSR1   = 6'd21, S_BR2    = 6'd22,
        S_MEM21  = 6'd23, S_LDI2   = 6'd24, S_MEM11  = 6'd25, S_LDI3   = 6'd26,
        S_MEM12  = 6'd27, S_TRAP2  = 6'd28, S_STI2   = 6'd29, S_STI3   = 6'd30,
        S_TRAP3  = 6'd31, S_DECODE = 6'd32, S_FETCH2 = 6'd33, S_FETCH3 = 6'd35,
        S_INT1   = 6'd49, S_INT2   = 6'd50, S_ERR    = 6'd63
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_err_q, mem_err_d;

    logic [3:0] opcode;
    logic       ben;
    logic       in_wait;
    logic       unused_ir;

    assign opcode    = IR[DATA_W-1 -: 4];
    assign ben       = (IR[11] & N) | (IR[10] & Z) | (IR[9] & P);
    assign in_wait   = state_q inside {S_FETCH2, S_TRAP2, S_LDI2, S_MEM11, S_STI2, S_MEM22};
    assign unused_ir = ^IR;
    assign MEM_ERR   = mem_err_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= S_FETCH1;
            cnt_q     <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mem_err_q <= mem_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        mem_err_d   = mem_err_q;
        LD_MAR      = 1'b0;
        LD_MDR      = 1'b0;
        LD_IR       = 1'b0;
        LD_PC       = 1'b0;
        LD_REG      = 1'b0;
        LD_BEN      = 1'b0;
        LD_CC       = 1'b0;
        GateMARMUX  = 1'b0;
        GateMDR     = 1'b0;
        GateALU     = 1'b0;
        GatePC      = 1'b0;
        MARMUXsel   = 1'b0;
        ADDR1MUXsel = 1'b0;
        ADDR2MUXsel = 2'b00;
        PCMUXsel    = 2'b00;
        SR1MUXsel   = 2'b00;
        DRMUXsel    = 2'b00;
        ALUK        = 2'b00;
        MEM_EN      = 1'b0;
        MEM_WE      = 1'b0;
        INT_ACK     = 1'b0;
        HALTED      = 1'b0;

        case (state_q)
            S_FETCH1: begin
                GatePC = 1'b1; LD_MAR = 1'b1; LD_PC = 1'b1;
                state_d = ((INT_EN != 0) && INT_REQ) ? S_INT1 : S_FETCH2;
            end
            S_FETCH2: begin
                MEM_EN = 1'b1; LD_MDR = 1'b1;
                if (READY) state_d = S_FETCH3;
            end
            S_FETCH3: begin
                GateMDR = 1'b1; LD_IR = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                LD_BEN = 1'b1;
                case (opcode)
                    4'b0001: state_d = S_ADD;
                    4'b0101: state_d = S_AND;
                    4'b1001: state_d = S_NOT;
                    4'b1110: state_d = S_LEA;
                    4'b0000: state_d = S_BR1;
                    4'b1100: state_d = S_JMP;
                    4'b0100: state_d = S_JSR;
                    4'b0010: state_d = S_LD;
                    4'b0110: state_d = S_LDR;
                    4'b1010: state_d = S_LDI1;
                    4'b0011: state_d = S_ST;
                    4'b0111: state_d = S_STR;
                    4'b1011: state_d = S_STI1;
                    4'b1111: state_d = S_TRAP1;
                    4'b1000: state_d = S_RTI;
                    default: state_d = S_FETCH1;
                endcase
            end
            S_ADD, S_AND, S_NOT: begin
                SR1MUXsel = 2'b01; GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
                ALUK = (state_q == S_AND) ? 2'b01 : ((state_q == S_NOT) ? 2'b10 : 2'b00);
                state_d = S_FETCH1;
            end
            S_LEA: begin
                ADDR2MUXsel = 2'b10; MARMUXsel = 1'b1; GateMARMUX = 1'b1;
                LD_REG = 1'b1; LD_CC = 1'b1;
                state_d = S_FETCH1;
            end
            S_BR1: state_d = ben ? S_BR2 : S_FETCH1;
            S_BR2: begin
                ADDR2MUXsel = 2'b10; PCMUXsel = 2'b10; LD_PC = 1'b1;
                state_d = S_FETCH1;
            end
            S_JMP, S_JSR0: begin
                SR1MUXsel = 2'b01; ADDR1MUXsel = 1'b1; PCMUXsel = 2'b10; LD_PC = 1'b1;
                state_d = S_FETCH1;
            end
            S_JSR: begin
                GatePC = 1'b1; DRMUXsel = 2'b01; LD_REG = 1'b1;
                state_d = IR[11] ? S_JSR1 : S_JSR0;
            end
            S_JSR1: begin
                ADDR2MUXsel = 2'b11; PCMUXsel = 2'b10; LD_PC = 1'b1;
                state_d = S_FETCH1;
            end
            // PC-relative and base+offset address generation into MAR.
            S_LD, S_LDI1, S_ST, S_STI1: begin
                ADDR2MUXsel = 2'b10; MARMUXsel = 1'b1; GateMARMUX = 1'b1; LD_MAR = 1'b1;
                state_d = (state_q == S_LD) ? S_MEM11 : (state_q == S_LDI1) ? S_LDI2 :
                          (state_q == S_ST) ? S_MEM21 : S_STI2;
            end
            S_LDR, S_STR: begin
                SR1MUXsel = 2'b01; ADDR1MUXsel = 1'b1; ADDR2MUXsel = 2'b01;
                MARMUXsel = 1'b1; GateMARMUX = 1'b1; LD_MAR = 1'b1;
                state_d = (state_q == S_LDR) ? S_MEM11 : S_MEM21;
            end
            S_MEM11, S_LDI2, S_STI2: begin
                MEM_EN = 1'b1; LD_MDR = 1'b1;
                if (READY) state_d = (state_q == S_MEM11) ? S_MEM12 :
                                     (state_q == S_LDI2) ? S_LDI3 : S_STI3;
            end
            S_MEM12: begin
                GateMDR = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
                state_d = S_FETCH1;
            end
            S_LDI3, S_STI3: begin
                GateMDR = 1'b1; LD_MAR = 1'b1;
                state_d = (state_q == S_LDI3) ? S_MEM11 : S_MEM21;
            end
            S_MEM21: begin
                ALUK = 2'b11; GateALU = 1'b1; LD_MDR = 1'b1;
                state_d = S_MEM22;
            end
            S_MEM22: begin
                MEM_EN = 1'b1; MEM_WE = 1'b1;
                if (READY) state_d = S_FETCH1;
            end
            S_TRAP1: begin
                GateMARMUX = 1'b1; LD_MAR = 1'b1;
                state_d = S_TRAP2;
            end
            // R7 capture rides along with the vector read; MDR loads from memory, not the bus.
            S_TRAP2: begin
                MEM_EN = 1'b1; LD_MDR = 1'b1; GatePC = 1'b1; DRMUXsel = 2'b01; LD_REG = 1'b1;
                if (READY) state_d = S_TRAP3;
            end
            S_TRAP3: begin
                GateMDR = 1'b1; PCMUXsel = 2'b01; LD_PC = 1'b1;
                state_d = S_FETCH1;
            end
            S_RTI: begin
                SR1MUXsel = 2'b10; ADDR1MUXsel = 1'b1; PCMUXsel = 2'b10; LD_PC = 1'b1;
                state_d = S_FETCH1;
            end
            S_INT1: begin
                GatePC = 1'b1; DRMUXsel = 2'b01; LD_REG = 1'b1; INT_ACK = 1'b1;
                state_d = S_INT2;
            end
            S_INT2: begin
                PCMUXsel = 2'b11; LD_PC = 1'b1;
                state_d = S_FETCH1;
            end
            S_ERR: HALTED = 1'b1;
            default: state_d = S_FETCH1;
        endcase

        // READY wins over the timeout when both land on the same cycle.
        if (in_wait && !READY) begin
            if ((MEM_WAIT_MAX != 0) && (cnt_q == CNT_W'(MEM_WAIT_MAX))) begin
                state_d   = S_ERR;
                mem_err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lc3_ctrl_fsm_p.sv
// Directed bench: per-cycle expected strobe vectors are queued with their stimulus and compared at the falling edge.
// A second instance with interrupts disabled shadows the same inputs.
module tb_lc3_ctrl_fsm_p;

    typedef struct packed {
        logic ld_mar, ld_mdr, ld_ir, ld_pc, ld_reg, ld_ben, ld_cc;
        logic g_marmux, g_mdr, g_alu, g_pc, marmux, addr1;
        logic [1:0] addr2, pcmux, sr1mux, drmux, aluk;
        logic mem_en, mem_we, int_ack, mem_err, halted;
    } outs_t;

    typedef struct {
        logic  rdy;
        logic  intr;
        outs_t exp;
        outs_t exp2;
    } step_t;

    logic        CLK = 1'b0, RESET = 1'b0, READY = 1'b1;
    logic        N = 1'b0, Z = 1'b0, P = 1'b0, INT_REQ = 1'b0;
    logic [15:0] IR = 16'h0000;
    wire outs_t  o1, o2;
    step_t       q[$];
    int          checks = 0, failures = 0;

    always #5 CLK = ~CLK;

    lc3_ctrl_fsm_p u_dut (
        .CLK(CLK), .RESET(RESET), .READY(READY), .IR(IR), .N(N), .Z(Z), .P(P), .INT_REQ(INT_REQ),
        .LD_MAR(o1.ld_mar), .LD_MDR(o1.ld_mdr), .LD_IR(o1.ld_ir), .LD_PC(o1.ld_pc),
        .LD_REG(o1.ld_reg), .LD_BEN(o1.ld_ben), .LD_CC(o1.ld_cc),
        .GateMARMUX(o1.g_marmux), .GateMDR(o1.g_mdr), .GateALU(o1.g_alu), .GatePC(o1.g_pc),
        .MARMUXsel(o1.marmux), .ADDR1MUXsel(o1.addr1), .ADDR2MUXsel(o1.addr2), .PCMUXsel(o1.pcmux),
        .SR1MUXsel(o1.sr1mux), .DRMUXsel(o1.drmux), .ALUK(o1.aluk),
        .MEM_EN(o1.mem_en), .MEM_WE(o1.mem_we), .INT_ACK(o1.int_ack),
        .MEM_ERR(o1.mem_err), .HALTED(o1.halted)
    );

    lc3_ctrl_fsm_p #(.INT_EN(0)) u_dut_noint (
        .CLK(CLK), .RESET(RESET), .READY(READY), .IR(IR), .N(N), .Z(Z), .P(P), .INT_REQ(INT_REQ),
        .LD_MAR(o2.ld_mar), .LD_MDR(o2.ld_mdr), .LD_IR(o2.ld_ir), .LD_PC(o2.ld_pc),
        .LD_REG(o2.ld_reg), .LD_BEN(o2.ld_ben), .LD_CC(o2.ld_cc),
        .GateMARMUX(o2.g_marmux), .GateMDR(o2.g_mdr), .GateALU(o2.g_alu), .GatePC(o2.g_pc),
        .MARMUXsel(o2.marmux), .ADDR1MUXsel(o2.addr1), .ADDR2MUXsel(o2.addr2), .PCMUXsel(o2.pcmux),
        .SR1MUXsel(o2.sr1mux), .DRMUXsel(o2.drmux), .ALUK(o2.aluk),
        .MEM_EN(o2.mem_en), .MEM_WE(o2.mem_we), .INT_ACK(o2.int_ack),
        .MEM_ERR(o2.mem_err), .HALTED(o2.halted)
    );

    // Expected strobes for each microstate, written from the LC-3 datapath control table.
    function automatic outs_t ex(input string k);
        outs_t o;
        o = '0;
        case (k)
            "F1":    begin o.g_pc = 1; o.ld_mar = 1; o.ld_pc = 1; end
            "RD":    begin o.mem_en = 1; o.ld_mdr = 1; end
            "F3":    begin o.g_mdr = 1; o.ld_ir = 1; end
            "DEC":   o.ld_ben = 1;
            "ADD":   begin o.sr1mux = 2'b01; o.g_alu = 1; o.ld_reg = 1; o.ld_cc = 1; end
            "AND":   begin o.sr1mux = 2'b01; o.g_alu = 1; o.ld_reg = 1; o.ld_cc = 1; o.aluk = 2'b01; end
            "NOT":   begin o.sr1mux = 2'b01; o.g_alu = 1; o.ld_reg = 1; o.ld_cc = 1; o.aluk = 2'b10; end
            "LEA":   begin o.addr2 = 2'b10; o.marmux = 1; o.g_marmux = 1; o.ld_reg = 1; o.ld_cc = 1; end
            "BR1":   o = '0;
            "BR2":   begin o.addr2 = 2'b10; o.pcmux = 2'b10; o.ld_pc = 1; end
            "JMP":   begin o.sr1mux = 2'b01; o.addr1 = 1; o.pcmux = 2'b10; o.ld_pc = 1; end
            "JSR":   begin o.g_pc = 1; o.drmux = 2'b01; o.ld_reg = 1; end
            "JSR1":  begin o.addr2 = 2'b11; o.pcmux = 2'b10; o.ld_pc = 1; end
            "ADR9":  begin o.addr2 = 2'b10; o.marmux = 1; o.g_marmux = 1; o.ld_mar = 1; end
            "ADR6":  begin o.sr1mux = 2'b01; o.addr1 = 1; o.addr2 = 2'b01; o.marmux = 1;
                           o.g_marmux = 1; o.ld_mar = 1; end
            "MEM12": begin o.g_mdr = 1; o.ld_reg = 1; o.ld_cc = 1; end
            "IND":   begin o.g_mdr = 1; o.ld_mar = 1; end
            "MEM21": begin o.aluk = 2'b11; o.g_alu = 1; o.ld_mdr = 1; end
            "WR":    begin o.mem_en = 1; o.mem_we = 1; end
            "TRAP1": begin o.g_marmux = 1; o.ld_mar = 1; end
            "TRAP2": begin o.mem_en = 1; o.ld_mdr = 1; o.g_pc = 1; o.drmux = 2'b01; o.ld_reg = 1; end
            "TRAP3": begin o.g_mdr = 1; o.pcmux = 2'b01; o.ld_pc = 1; end
            "RTI":   begin o.sr1mux = 2'b10; o.addr1 = 1; o.pcmux = 2'b10; o.ld_pc = 1; end
            "INT1":  begin o.g_pc = 1; o.drmux = 2'b01; o.ld_reg = 1; o.int_ack = 1; end
            "INT2":  begin o.pcmux = 2'b11; o.ld_pc = 1; end
            "ERR":   begin o.mem_err = 1; o.halted = 1; end
            default: o = '1;
        endcase
        return o;
    endfunction

    task automatic push2(input string k1, input string k2, input logic rdy, input logic intr);
        step_t s;
        s.rdy = rdy; s.intr = intr; s.exp = ex(k1); s.exp2 = ex(k2);
        q.push_back(s);
    endtask

    task automatic pushs(input string k, input logic rdy, input logic intr);
        push2(k, k, rdy, intr);
    endtask

    task automatic push(input string k);
        push2(k, k, 1'b1, 1'b0);
    endtask

    task automatic fetch();
        push("F1"); push("RD"); push("F3"); push("DEC");
    endtask

    task automatic chk(input outs_t obs, input outs_t exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drains the queue one clock per entry; the queue length bounds the run.
    task automatic run(input string name);
        int n;
        n = q.size();
        for (int i = 0; i < n; i++) begin
            step_t s;
            s = q.pop_front();
            READY = s.rdy;
            INT_REQ = s.intr;
            @(negedge CLK);
            chk(o1, s.exp, $sformatf("%s[%0d]", name, i));
            chk(o2, s.exp2, $sformatf("%s[%0d]noint", name, i));
            @(posedge CLK);
            #1;
        end
        $display("txn %s ir=%h steps=%0d", name, IR, n);
    endtask

    // Asynchronous reset mid-cycle: both instances must show FETCH1 strobes immediately.
    task automatic do_reset(input string name);
        READY = 1'b1; INT_REQ = 1'b0;
        #2 RESET = 1'b1;
        #1;
        chk(o1, ex("F1"), {name, "_async"});
        chk(o2, ex("F1"), {name, "_async_noint"});
        @(posedge CLK);
        #1 RESET = 1'b0;
        $display("txn %s", name);
    endtask

    initial begin
        #2 RESET = 1'b1;
        #1;
        chk(o1, ex("F1"), "reset");
        chk(o2, ex("F1"), "reset_noint");
        @(posedge CLK);
        #1 RESET = 1'b0;

        IR = 16'h1261; fetch(); push("ADD"); run("ADD");
        IR = 16'h5260; fetch(); push("AND"); run("AND");
        IR = 16'h927F; fetch(); push("NOT"); run("NOT");
        IR = 16'hE205; fetch(); push("LEA"); run("LEA");
        IR = 16'h0402; Z = 1'b1; fetch(); push("BR1"); push("BR2"); run("BRz_taken");
        N = 1'b1; Z = 1'b0; P = 1'b1;
        fetch(); push("BR1"); run("BRz_not_taken");
        N = 1'b0; P = 1'b0;
        IR = 16'hC1C0; fetch(); push("JMP"); run("JMP");
        IR = 16'h4803; fetch(); push("JSR"); push("JSR1"); run("JSR");
        IR = 16'h4080; fetch(); push("JSR"); push("JMP"); run("JSRR");
        IR = 16'h8000; fetch(); push("RTI"); run("RTI");
        IR = 16'hD000; fetch(); run("RESERVED");

        IR = 16'h2002; fetch(); push("ADR9");
        for (int i = 0; i < 3; i++) pushs("RD", 1'b0, 1'b0);
        pushs("RD", 1'b1, 1'b0); push("MEM12"); run("LD_wait3");
        IR = 16'h6042; fetch(); push("ADR6"); push("RD"); push("MEM12"); run("LDR");
        IR = 16'hA002; fetch(); push("ADR9"); push("RD"); push("IND"); push("RD"); push("MEM12"); run("LDI");
        IR = 16'h3002; fetch(); push("ADR9"); push("MEM21"); push("WR"); run("ST");
        IR = 16'h7042; fetch(); push("ADR6"); push("MEM21"); push("WR"); run("STR");
        IR = 16'hB002; fetch(); push("ADR9"); push("RD"); push("IND"); push("MEM21"); push("WR"); run("STI");
        IR = 16'hF025; fetch(); push("TRAP1"); push("TRAP2"); push("TRAP3"); run("TRAP");

        // READY arrives on the very cycle the counter sits at the limit: no error.
        IR = 16'h2002; fetch(); push("ADR9");
        for (int i = 0; i < 15; i++) pushs("RD", 1'b0, 1'b0);
        pushs("RD", 1'b1, 1'b0); push("MEM12"); run("LD_limit_ready");

        IR = 16'h1261;
        push("F1"); push("RD"); push("F3");
        pushs("DEC", 1'b1, 1'b1); pushs("ADD", 1'b1, 1'b1);
        push2("F1", "F1", 1'b1, 1'b1);
        push2("INT1", "RD", 1'b1, 1'b0);
        push2("INT2", "F3", 1'b1, 1'b0);
        push2("F1", "DEC", 1'b1, 1'b0);
        run("INT_during_ADD");
        do_reset("reset_after_int");

        IR = 16'hB002; fetch(); push("ADR9");
        for (int i = 0; i < 3; i++) pushs("RD", 1'b0, 1'b0);
        run("STI_stall");
        do_reset("reset_mid_STI2");

        IR = 16'h3002; fetch(); push("ADR9"); push("MEM21");
        for (int i = 0; i < 16; i++) pushs("WR", 1'b0, 1'b0);
        pushs("ERR", 1'b0, 1'b1); pushs("ERR", 1'b0, 1'b1);
        pushs("ERR", 1'b1, 1'b1); pushs("ERR", 1'b1, 1'b0);
        run("ST_timeout");
        do_reset("reset_from_ERR");

        IR = 16'h1261; fetch(); push("ADD"); push("F1"); run("ADD_after_ERR");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
